channel_tx_arbiter: RTL and testbench
=====================================

# channel_tx_arbiter

Round-robin scheduler that shares the single channel serializer TX path between CH_NUM per-channel first-word-fall-through FIFOs. It grants one channel at a time for a whole frame (until TLAST), pops that channel's FIFO under serializer back-pressure, and presents a registered word stream with a write strobe to the serializer input. It sits between the per-channel trigger/FIFO stage and channel_serializer in the TX_ACLK domain.

## Interface
- CH_NUM, 8: number of requesting channels, ≥2.
- TDATA_WIDTH, 64: word width.
- STALL_TIMEOUT, 256: mid-frame empty-stall limit in cycles. Used only with CH_STALL_TIMEOUT_EN.

Ports:
- TX_ACLK  in  1  TX clock; all logic is rising-edge.
- TX_ARESET  in  1  asynchronous, active-high reset.
- CH_TDATA  in  CH_NUM*TDATA_WIDTH  FIFO heads; channel i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- CH_TUSER  in  CH_NUM  per-channel TUSER of the head word.
- CH_TLAST  in  CH_NUM  per-channel TLAST of the head word.
- CH_EMPTY  in  CH_NUM  FIFO empty flags; head data is valid when low.
- CH_RE_EN  out  CH_NUM  one-hot FIFO pop strobes.
- PLS_WAIT  in  1  serializer hold request.
- M_TDATA  out  TDATA_WIDTH  registered output word.
- M_TUSER  out  1  registered TUSER.
- M_TLAST  out  1  registered TLAST.
- M_VALID  out  1  write strobe, one word per high cycle.
- GRANT_CH  out  $clog2(CH_NUM)  currently or last granted channel.
- BUSY  out  1  high in STREAM.
- STALL_ERR  out  1  sticky stall-timeout flag.

## Operation
- States: IDLE, STREAM.
- **IDLE**
  - Search channels starting at (last_grant+1) mod CH_NUM, wrapping.
  - The first channel with CH_EMPTY low wins. Register it into GRANT_CH and last_grant, then go to STREAM.
  - If no channel is ready, stay in IDLE.
  - CH_RE_EN is all zero in IDLE.
- **STREAM**
  - pop = !PLS_WAIT && !CH_EMPTY[GRANT_CH].
  - CH_RE_EN[GRANT_CH] = pop (combinational). All other bits are 0.
  - On pop, register CH_TDATA, CH_TUSER and CH_TLAST of GRANT_CH into the M_* outputs, and set M_VALID=1 on the next cycle. Otherwise M_VALID=0 on the next cycle.
  - A popped word with TLAST=1 returns the block to IDLE on the next cycle.
- A granted channel that goes empty mid-frame holds the grant. The block stays in STREAM, pops nothing and does not switch channels.
- Other channels' CH_EMPTY changes during STREAM are ignored.
- The round-robin pointer advances only on grant, so a just-served channel has lowest priority in the next search.
- A one-word frame (TLAST on the first word) is legal.
- Reset values:
  - state IDLE.
  - last_grant = CH_NUM-1, so channel 0 is searched first.
  - GRANT_CH=0.
  - M_TDATA=0, M_TUSER=0, M_TLAST=0, M_VALID=0.
  - BUSY=0, STALL_ERR=0.
- Reset mid-frame: all outputs take their reset values immediately (asynchronous). CH_RE_EN drops combinationally. The partial frame is abandoned; the upstream stage owns the FIFO flush.

## Timing
- Cycle N: IDLE sees CH_EMPTY[k]=0.
- N+1: STREAM, GRANT_CH=k, first possible pop.
- N+2: first M_VALID.
- Latency from pop to M_VALID is exactly 1 cycle.
- Throughput is 1 word/cycle while unstalled. A frame of L words with no stalls occupies L+1 cycles including arbitration.
- There is a minimum of 1 IDLE cycle between frames: TLAST popped at cycle K, IDLE at K+1, next grant visible at K+2.
- PLS_WAIT gates pops in the same cycle.
  - The serializer must accept the single word already registered when PLS_WAIT rises: M_VALID may be high in the cycle after PLS_WAIT asserts.
  - No further words follow until PLS_WAIT falls.
- PLS_WAIT has no effect in IDLE; arbitration proceeds regardless.

## Configuration
- **CH_STALL_TIMEOUT_EN defined**
  - A counter of width $clog2(STALL_TIMEOUT+1) increments each STREAM cycle with CH_EMPTY[GRANT_CH]=1 and PLS_WAIT=0.
  - It clears on any pop and on entry to STREAM. PLS_WAIT cycles hold it.
  - On reaching STALL_TIMEOUT: set STALL_ERR (sticky until reset), go to IDLE next cycle, and emit no word.
  - The pointer has already advanced, so the next search starts past the faulty channel.
- **Not defined:** no counter, STALL_ERR tied 0, and the grant is held indefinitely.

## Test plan
- Channels 0, 2 and 5 each hold a 3-word frame, all non-empty at reset release → frames emitted in order 0, 2, 5. Each has 3 consecutive M_VALID with M_TLAST on the third. GRANT_CH is 0/2/5, with 1 idle cycle between frames.
- Channel 3 streams 4 words, PLS_WAIT high for cycles 2–4 of STREAM → CH_RE_EN[3] low in those cycles, at most 1 M_VALID after PLS_WAIT rises, all 4 words delivered intact in order.
- Channel 1 mid-frame empty for 10 cycles while channel 4 is non-empty → GRANT_CH stays 1, no channel-4 pops until channel 1's TLAST, then channel 4 granted.
- Channels 6 and 7 with continuous back-to-back 1-word frames (TLAST on every word), CH_NUM=8 → grants alternate 6, 7, 6, 7; the pointer wraps through 0 without a spurious grant.
- TX_ARESET pulsed on the 2nd word of a 5-word frame → M_VALID, CH_RE_EN and BUSY go 0 asynchronously. After release, channel 0 is searched first.
- With CH_STALL_TIMEOUT_EN and STALL_TIMEOUT=16, granted channel 2 empties mid-frame → STALL_ERR rises after 16 stall cycles, the block returns to IDLE, and channel 3 is granted next if ready.

Source files
------------

// File: rtl/channel_tx_arbiter.sv
// Round-robin frame arbiter: grants one FIFO channel per frame and streams it to the serializer.
// Optional mid-frame stall timeout is enabled by defining CH_STALL_TIMEOUT_EN.
module channel_tx_arbiter #(
  parameter int unsigned CH_NUM        = 8,
  parameter int unsigned TDATA_WIDTH   = 64,
  parameter int unsigned STALL_TIMEOUT = 256
) (
  input  logic                          TX_ACLK,
  input  logic                          TX_ARESET,
  input  logic [CH_NUM*TDATA_WIDTH-1:0] CH_TDATA,
  input  logic [CH_NUM-1:0]             CH_TUSER,
  input  logic [CH_NUM-1:0]             CH_TLAST,
  input  logic [CH_NUM-1:0]             CH_EMPTY,
  output logic [CH_NUM-1:0]             CH_RE_EN,
  input  logic                          PLS_WAIT,
  output logic [TDATA_WIDTH-1:0]        M_TDATA,
  output logic                          M_TUSER,
  output logic                          M_TLAST,
  output logic                          M_VALID,
  output logic [$clog2(CH_NUM)-1:0]     GRANT_CH,
  output logic                          BUSY,
  output logic                          STALL_ERR
);

  localparam int unsigned GW = $clog2(CH_NUM);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                 r_state;
  logic [GW-1:0]          r_last_grant;
  logic [GW-1:0]          r_grant;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic                   r_tuser;
  logic                   r_tlast;
  logic                   r_valid;

  logic                   w_found;
  logic [GW-1:0]          w_sel;
  logic [TDATA_WIDTH-1:0] w_head_data;
  logic                   w_head_user;
  logic                   w_head_last;
  logic                   w_head_empty;
  logic                   w_pop;
  logic                   w_timeout;

  function automatic logic [GW-1:0] f_wrap(input int unsigned v);
    return GW'(v % CH_NUM);
  endfunction

  // Descending scan so the nearest channel after the pointer is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned i = CH_NUM; i >= 1; i--) begin
      if (!CH_EMPTY[f_wrap(32'(r_last_grant) + i)]) begin
        w_found = 1'b1;
        w_sel   = f_wrap(32'(r_last_grant) + i);
      end
    end
  end

  always_comb begin
    w_head_data  = '0;
    w_head_user  = 1'b0;
    w_head_last  = 1'b0;
    w_head_empty = 1'b1;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (r_grant == GW'(i)) begin
        w_head_data  = CH_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH];
        w_head_user  = CH_TUSER[i];
        w_head_last  = CH_TLAST[i];
        w_head_empty = CH_EMPTY[i];
      end
    end
  end

  assign w_pop = (r_state == StStream) && !PLS_WAIT && !w_head_empty;

  always_comb begin
    CH_RE_EN = '0;
    if (w_pop) CH_RE_EN[r_grant] = 1'b1;
  end

`ifdef CH_STALL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(STALL_TIMEOUT + 1);

  logic [CW-1:0] r_stall_cnt;
  logic          r_stall_err;
  logic          w_stall_tick;

  assign w_stall_tick = (r_state == StStream) && w_head_empty && !PLS_WAIT;
  assign w_timeout    = w_stall_tick && (r_stall_cnt == CW'(STALL_TIMEOUT - 1));

  // Clearing while idle covers the clear-on-entry to STREAM.
  always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
    if (TX_ARESET) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      if (r_state == StIdle || w_pop || w_timeout) begin
        r_stall_cnt <= '0;
      end else if (w_stall_tick) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_timeout) r_stall_err <= 1'b1;
    end
  end

  assign STALL_ERR = r_stall_err;
`else
  logic w_unused_stall;

  assign w_unused_stall = ^STALL_TIMEOUT;
  assign w_timeout      = 1'b0;
  assign STALL_ERR      = 1'b0;
`endif

  always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
    if (TX_ARESET) begin
      r_state      <= StIdle;
      r_last_grant <= GW'(CH_NUM - 1);
      r_grant      <= '0;
      r_tdata      <= '0;
      r_tuser      <= 1'b0;
      r_tlast      <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_tdata <= w_head_data;
        r_tuser <= w_head_user;
        r_tlast <= w_head_last;
      end
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_state      <= StStream;
          end
        end
        StStream: begin
          if ((w_pop && w_head_last) || w_timeout) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign M_TDATA  = r_tdata;
  assign M_TUSER  = r_tuser;
  assign M_TLAST  = r_tlast;
  assign M_VALID  = r_valid;
  assign GRANT_CH = r_grant;
  assign BUSY     = (r_state == StStream);

endmodule

// File: tb/tb_channel_tx_arbiter.sv
// Bench for channel_tx_arbiter: FIFO models per channel, scoreboard of expected output words.
module tb_channel_tx_arbiter;

  localparam int unsigned CH = 8;
  localparam int unsigned W  = 64;

  logic            TX_ACLK = 1'b0;
  logic            TX_ARESET = 1'b1;
  logic [CH*W-1:0] CH_TDATA;
  logic [CH-1:0]   CH_TUSER;
  logic [CH-1:0]   CH_TLAST;
  logic [CH-1:0]   CH_EMPTY;
  logic [CH-1:0]   CH_RE_EN;
  logic            PLS_WAIT = 1'b0;
  logic [W-1:0]    M_TDATA;
  logic            M_TUSER;
  logic            M_TLAST;
  logic            M_VALID;
  logic [2:0]      GRANT_CH;
  logic            BUSY;
  logic            STALL_ERR;

  channel_tx_arbiter #(
    .CH_NUM       (CH),
    .TDATA_WIDTH  (W),
    .STALL_TIMEOUT(16)
  ) dut (
    .TX_ACLK  (TX_ACLK),
    .TX_ARESET(TX_ARESET),
    .CH_TDATA (CH_TDATA),
    .CH_TUSER (CH_TUSER),
    .CH_TLAST (CH_TLAST),
    .CH_EMPTY (CH_EMPTY),
    .CH_RE_EN (CH_RE_EN),
    .PLS_WAIT (PLS_WAIT),
    .M_TDATA  (M_TDATA),
    .M_TUSER  (M_TUSER),
    .M_TLAST  (M_TLAST),
    .M_VALID  (M_VALID),
    .GRANT_CH (GRANT_CH),
    .BUSY     (BUSY),
    .STALL_ERR(STALL_ERR)
  );

  always #5 TX_ACLK = ~TX_ACLK;

  typedef struct {
    logic [63:0] data;
    logic        user;
    logic        last;
    int unsigned ch;
  } word_t;

  typedef struct {
    int unsigned        len;
    int unsigned        n;
    logic [7:0][2:0]    order;
  } vec_t;

  word_t       fq [CH][$];
  word_t       sb [$];
  word_t       e;
  vec_t        tbl [5];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [CH-1:0] pops;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int unsigned len, input int unsigned n,
                              input int unsigned o0, input int unsigned o1,
                              input int unsigned o2, input int unsigned o3,
                              input int unsigned o4, input int unsigned o5,
                              input int unsigned o6, input int unsigned o7);
    vec_t r;
    r.len = len;
    r.n   = n;
    r.order[0] = 3'(o0); r.order[1] = 3'(o1); r.order[2] = 3'(o2); r.order[3] = 3'(o3);
    r.order[4] = 3'(o4); r.order[5] = 3'(o5); r.order[6] = 3'(o6); r.order[7] = 3'(o7);
    return r;
  endfunction

  task automatic refresh();
    for (int i = 0; i < CH; i++) begin
      if (fq[i].size() == 0) begin
        CH_EMPTY[i]       = 1'b1;
        CH_TDATA[i*W +: W] = 64'hDEAD_BEEF_DEAD_BEEF;
        CH_TUSER[i]       = 1'b0;
        CH_TLAST[i]       = 1'b0;
      end else begin
        CH_EMPTY[i]       = 1'b0;
        CH_TDATA[i*W +: W] = fq[i][0].data;
        CH_TUSER[i]       = fq[i][0].user;
        CH_TLAST[i]       = fq[i][0].last;
      end
    end
  endtask

  task automatic load_words(input int unsigned ch, input int unsigned n, input bit end_frame,
                            input bit to_sb);
    word_t w;
    for (int unsigned k = 0; k < n; k++) begin
      w.data = {$urandom, $urandom};
      w.user = 1'($urandom);
      w.last = end_frame && (k == n - 1);
      w.ch   = ch;
      fq[ch].push_back(w);
      if (to_sb) sb.push_back(w);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge TX_ACLK);
      c++;
    end
    check({name, "_drained"}, 64'(sb.size() == 0), 64'd1);
    sb.delete();
    @(negedge TX_ACLK);
    check({name, "_idle_after"}, 64'(BUSY), 64'd0);
  endtask

  // FIFO model: pops sampled mid-cycle, applied just after the edge the DUT consumed them on.
  initial begin
    refresh();
    forever begin
      @(negedge TX_ACLK);
      pops = CH_RE_EN;
      @(posedge TX_ACLK);
      #1;
      for (int i = 0; i < CH; i++) begin
        if (pops[i] && fq[i].size() > 0) fq[i].delete(0);
      end
      refresh();
    end
  end

  always @(negedge TX_ACLK) begin
    if (prev_last) check("idle_gap", 64'(M_VALID), 64'd0);
    prev_last = M_VALID && M_TLAST;
    if (!BUSY) check("re_idle", 64'(CH_RE_EN), 64'd0);
    else if (CH_RE_EN != '0) check("re_grant", 64'(CH_RE_EN), 64'(8'd1 << GRANT_CH));
    if (M_VALID) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(M_VALID), 64'd0);
      end else begin
        e = sb.pop_front();
        check("tdata", M_TDATA, e.data);
        check("tuser", 64'(M_TUSER), 64'(e.user));
        check("tlast", 64'(M_TLAST), 64'(e.last));
        check("grant_ch", 64'(GRANT_CH), 64'(e.ch));
      end
    end
  end

  initial begin
    int c;
    int nv;
    word_t ch4_words [$];

    tbl[0] = mk(3, 3, 0, 2, 5, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 4, 6, 7, 6, 7, 0, 0, 0, 0);
    tbl[2] = mk(2, 8, 0, 1, 2, 3, 4, 5, 6, 7);
    tbl[3] = mk(1, 2, 1, 3, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(2, 2, 5, 0, 0, 0, 0, 0, 0, 0);

    // Reset values
    repeat (2) @(negedge TX_ACLK);
    check("rst_valid", 64'(M_VALID), 64'd0);
    check("rst_tdata", M_TDATA, 64'd0);
    check("rst_tuser", 64'(M_TUSER), 64'd0);
    check("rst_tlast", 64'(M_TLAST), 64'd0);
    check("rst_grant", 64'(GRANT_CH), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_stall", 64'(STALL_ERR), 64'd0);
    check("rst_re", 64'(CH_RE_EN), 64'd0);
    #1 TX_ARESET = 1'b0;

    // Round-robin table: frames are preloaded, order lists the expected grant sequence
    for (int t = 0; t < 5; t++) begin
      for (int unsigned k = 0; k < tbl[t].n; k++) begin
        load_words(32'(tbl[t].order[k]), tbl[t].len, 1'b1, 1'b1);
      end
      wait_drain($sformatf("tbl%0d", t), 200);
    end

    // PLS_WAIT hold on channel 3 during STREAM cycles 2-4
    load_words(3, 4, 1'b1, 1'b1);
    c = 0;
    do begin
      @(negedge TX_ACLK);
      c++;
    end while (!(BUSY && GRANT_CH == 3'd3) && c < 50);
    check("pls_grant_wait", 64'(c < 50), 64'd1);
    check("pls_first_pop", 64'(CH_RE_EN), 64'h08);
    @(posedge TX_ACLK);
    #1 PLS_WAIT = 1'b1;
    nv = 0;
    repeat (3) begin
      @(negedge TX_ACLK);
      check("pls_re_held", 64'(CH_RE_EN), 64'd0);
      nv += int'(M_VALID);
    end
    @(posedge TX_ACLK);
    #1 PLS_WAIT = 1'b0;
    check("pls_valid_cnt", 64'(nv), 64'd1);
    wait_drain("pls", 100);

    // Channel 1 empties mid-frame while channel 4 waits
    load_words(1, 2, 1'b0, 1'b1);
    c = 0;
    do begin
      @(negedge TX_ACLK);
      c++;
    end while (!(BUSY && GRANT_CH == 3'd1) && c < 50);
    check("hold_grant_wait", 64'(c < 50), 64'd1);
    load_words(4, 2, 1'b1, 1'b0);
    ch4_words = fq[4];
    c = 0;
    while (fq[1].size() != 0 && c < 50) begin
      @(negedge TX_ACLK);
      c++;
    end
    repeat (10) begin
      @(negedge TX_ACLK);
      check("hold_grant", 64'(GRANT_CH), 64'd1);
      check("hold_busy", 64'(BUSY), 64'd1);
      check("hold_no_pop", 64'(CH_RE_EN), 64'd0);
    end
    load_words(1, 2, 1'b1, 1'b1);
    foreach (ch4_words[i]) sb.push_back(ch4_words[i]);
    wait_drain("hold", 100);

    // Asynchronous reset during the 2nd word of a 5-word frame on channel 2
    load_words(2, 5, 1'b1, 1'b1);
    c = 0;
    do begin
      @(negedge TX_ACLK);
      c++;
    end while (!M_VALID && c < 50);
    check("arst_wait", 64'(c < 50), 64'd1);
    #1 TX_ARESET = 1'b1;
    #1;
    check("arst_valid", 64'(M_VALID), 64'd0);
    check("arst_re", 64'(CH_RE_EN), 64'd0);
    check("arst_busy", 64'(BUSY), 64'd0);
    check("arst_grant", 64'(GRANT_CH), 64'd0);
    check("arst_tdata", M_TDATA, 64'd0);
    sb.delete();
    fq[2].delete();
    @(negedge TX_ACLK);
    #1 TX_ARESET = 1'b0;
    load_words(0, 1, 1'b1, 1'b1);
    load_words(4, 1, 1'b1, 1'b1);
    wait_drain("arst_ptr", 100);

`ifdef CH_STALL_TIMEOUT_EN
    // Channel 2 stalls mid-frame; timeout after 16 stall cycles, then channel 3 ahead of 1
    load_words(2, 2, 1'b0, 1'b1);
    c  = 0;
    nv = 0;
    while (nv < 2 && c < 50) begin
      @(negedge TX_ACLK);
      if (CH_RE_EN[2]) nv++;
      c++;
    end
    check("stall_pops", 64'(nv), 64'd2);
    c = 0;
    do begin
      @(negedge TX_ACLK);
      c++;
    end while (!STALL_ERR && c < 40);
    check("stall_cycles", 64'(c), 64'd17);
    check("stall_idle", 64'(BUSY), 64'd0);
    load_words(3, 1, 1'b1, 1'b1);
    load_words(1, 1, 1'b1, 1'b1);
    wait_drain("stall_next", 100);
    check("stall_sticky", 64'(STALL_ERR), 64'd1);
`else
    check("stall_tied", 64'(STALL_ERR), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
